// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves EX-stage conditional branches and trains a table of
// 2-bit saturating counters. Define BRU_STATS_EN to add branch/mispredict counters.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic            res_illegal
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    logic             taken;
    logic             legal;
    logic             accept;
    logic             update;
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] if_idx;
    logic [1:0]       bht_q [BHT_ENTRIES];

    logic res_valid_q, res_taken_q, res_mispredict_q, res_illegal_q;
    logic res_valid_d, res_taken_d, res_mispredict_d, res_illegal_d;

    // Address bits outside the table index carry no information for prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0],
                              if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        if (up) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (ex_funct3)
            F3_BEQ:  taken = (ex_rs1 == ex_rs2);
            F3_BNE:  taken = (ex_rs1 != ex_rs2);
            F3_BLT:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            F3_BGE:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            F3_BLTU: taken = (ex_rs1 <  ex_rs2);
            F3_BGEU: taken = (ex_rs1 >= ex_rs2);
            default: legal = 1'b0;
        endcase
    end

    assign accept = ex_valid & ~flush;
    assign update = accept & legal;
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_idx = if_pc[IDX_W+1:2];

    always_comb begin
        res_valid_d      = accept;
        res_taken_d      = update & taken;
        res_mispredict_d = update & (taken != ex_pred_taken);
        res_illegal_d    = accept & ~legal;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
            res_illegal_q    <= 1'b0;
        end else begin
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_mispredict_q <= res_mispredict_d;
            res_illegal_q    <= res_illegal_d;
        end
    end

    // NOTE: the table must come out of reset weakly not-taken, so it is built from resettable
    // flops rather than a RAM macro that cannot be cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (update) begin
            bht_q[ex_idx] <= sat_step(bht_q[ex_idx], taken);
        end
    end

    // Reading the current array contents gives read-before-write on a same-entry update.
    assign if_pred_taken  = bht_q[if_idx][1];
    assign res_valid      = res_valid_q;
    assign res_taken      = res_taken_q;
    assign res_mispredict = res_mispredict_q;
    assign res_illegal    = res_illegal_q;

`ifdef BRU_STATS_EN
    logic [31:0] stat_branches_q, stat_mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            if (update)           stat_branches_q    <= stat_branches_q + 32'd1;
            if (res_mispredict_d) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a table-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;
    localparam int N    = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush, ex_valid, ex_pred_taken;
    logic [XLEN-1:0] ex_rs1, ex_rs2, ex_pc, if_pc;
    logic [2:0]      ex_funct3;
    logic            if_pred_taken, res_valid, res_taken, res_mispredict, res_illegal;
`ifdef BRU_STATS_EN
    logic [31:0]     stat_branches, stat_mispredicts;
`endif

    branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
        .res_illegal(res_illegal)
`ifdef BRU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: counters as integers, outcomes from the ISA rules ----------------
    int          bht_m [N];
    bit          e_valid, e_taken, e_mis, e_ill;
    int unsigned s_br, s_mis;

    function automatic bit outcome(input bit [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   output bit legal);
        legal = 1'b1;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: begin legal = 1'b0; return 1'b0; end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) bht_m[i] = 1;
            {e_valid, e_taken, e_mis, e_ill} = 4'b0;
            s_br = 0;
            s_mis = 0;
        end else begin
            bit lg, tk;
            int idx;
            tk  = outcome(ex_funct3, ex_rs1, ex_rs2, lg);
            idx = int'(ex_pc[7:2]);
            {e_valid, e_taken, e_mis, e_ill} = 4'b0;
            if (ex_valid && !flush) begin
                e_valid = 1'b1;
                if (lg) begin
                    e_taken = tk;
                    e_mis   = (tk != ex_pred_taken);
                    s_br++;
                    if (e_mis) s_mis++;
                    bht_m[idx] = tk ? ((bht_m[idx] < 3) ? bht_m[idx] + 1 : 3)
                                    : ((bht_m[idx] > 0) ? bht_m[idx] - 1 : 0);
                end else begin
                    e_ill = 1'b1;
                end
            end
        end
    end

    // ---------------- single compare process, opposite clock edge ----------------
    always @(negedge clk) begin
        check("res_valid",      res_valid,      e_valid);
        check("res_taken",      res_taken,      e_taken);
        check("res_mispredict", res_mispredict, e_mis);
        check("res_illegal",    res_illegal,    e_ill);
        check("if_pred_taken",  if_pred_taken,  bht_m[int'(if_pc[7:2])] >= 2);
`ifdef BRU_STATS_EN
        check("stat_branches",    stat_branches,    s_br);
        check("stat_mispredicts", stat_mispredicts, s_mis);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit fl, input bit [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input bit pred);
        ex_valid = v; flush = fl; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
        ex_pc = pc; ex_pred_taken = pred;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit [2:0]    f3;
        logic [31:0] a;
        logic [31:0] b;
        bit          exp;
    } vec_t;

    vec_t vecs[9] = '{
        '{3'd1, 32'h5,        32'h5,        1'b0},
        '{3'd1, 32'h0,        32'h80000000, 1'b1},
        '{3'd4, 32'h80000000, 32'h7FFFFFFF, 1'b1},
        '{3'd4, 32'h5,        32'h5,        1'b0},
        '{3'd5, 32'h7FFFFFFF, 32'h80000000, 1'b1},
        '{3'd5, 32'h5,        32'h5,        1'b1},
        '{3'd6, 32'h80000000, 32'h7FFFFFFF, 1'b0},
        '{3'd7, 32'h0,        32'hFFFFFFFF, 1'b0},
        '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1}
    };

`ifdef BRU_STATS_EN
    int unsigned br_before;
`endif

    initial begin
        rst_n = 1'b0;
        if_pc = '0;
        drive(0, 0, 3'd0, '0, '0, '0, 0);
        #12 rst_n = 1'b1;
        #1;
        check("reset res_valid", res_valid, 1'b0);
        check("reset if_pred",   if_pred_taken, 1'b0);
        tick();

        // Signed vs unsigned view of the same operands.
        drive(1, 0, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h204, 0);
        tick();
        check("blt signed taken", res_taken, 1'b1);
        check("blt mispredict",   res_mispredict, 1'b1);
        drive(1, 0, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h208, 1);
        tick();
        check("bltu not taken",   res_taken, 1'b0);
        check("bltu mispredict",  res_mispredict, 1'b1);

        // BEQ trains entry 0; lookup in the update cycle still sees the old counter.
        drive(1, 0, 3'b000, 32'h1234, 32'h1234, 32'h100, 0);
        if_pc = 32'h100;
        #1 check("rbw if_pred old", if_pred_taken, 1'b0);
        tick();
        check("beq taken",      res_taken, 1'b1);
        check("beq mispredict", res_mispredict, 1'b1);
        idle();
        #1 check("beq trained pred", if_pred_taken, 1'b1);
        tick();

        // Four taken then one not-taken on one entry, back to back.
        if_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'b000, 32'h7, 32'h7, 32'h40, 1);
            tick();
        end
        check("model ctr 11", bht_m[16], 3);
        check("ctr 11 pred",  if_pred_taken, 1'b1);
        drive(1, 0, 3'b000, 32'h1, 32'h2, 32'h40, 1);
        tick();
        check("model ctr 10",  bht_m[16], 2);
        check("ctr 10 pred",   if_pred_taken, 1'b1);
        check("nt mispredict", res_mispredict, 1'b1);
        drive(1, 0, 3'b000, 32'h1, 32'h2, 32'h40, 1);
        tick();
        check("ctr 01 pred", if_pred_taken, 1'b0);
        drive(1, 0, 3'b000, 32'h7, 32'h7, 32'h40, 0);
        tick();

        // Illegal kinds: result flagged, table untouched.
        drive(1, 0, 3'b010, 32'h3, 32'h3, 32'h80, 1);
        if_pc = 32'h80;
        tick();
        check("illegal valid",  res_valid, 1'b1);
        check("illegal flag",   res_illegal, 1'b1);
        check("illegal taken",  res_taken, 1'b0);
        check("illegal mispr",  res_mispredict, 1'b0);
        drive(1, 0, 3'b011, 32'h3, 32'h4, 32'h80, 0);
        tick();
        check("illegal011 flag", res_illegal, 1'b1);
        idle();
        #1 check("illegal pred", if_pred_taken, 1'b0);
        check("model illegal ctr", bht_m[32], 1);
        tick();

        // Flushed branch: nothing comes out, nothing trains.
`ifdef BRU_STATS_EN
        br_before = stat_branches;
`endif
        drive(1, 1, 3'b000, 32'h5, 32'h5, 32'hC0, 0);
        if_pc = 32'hC0;
        tick();
        check("flush no valid", res_valid, 1'b0);
        drive(1, 1, 3'b000, 32'h5, 32'h5, 32'hC0, 0);
        tick();
        check("flush no train", if_pred_taken, 1'b0);
`ifdef BRU_STATS_EN
        check("flush no stat", stat_branches, br_before);
`endif

        // Table of compare kinds at operand extremes, issued every cycle.
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, vecs[i].f3, vecs[i].a, vecs[i].b, 32'h300 + 32'(4 * i), i[0]);
            tick();
            check($sformatf("vec%0d taken", i), res_taken, vecs[i].exp);
            check($sformatf("vec%0d mispr", i), res_mispredict, vecs[i].exp ^ i[0]);
        end

        // Train entry 16 to strongly taken, then reset with a branch in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 3'b000, 32'h9, 32'h9, 32'h40, 0);
            tick();
        end
        if_pc = 32'h40;
        #1 check("pre-reset pred", if_pred_taken, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst res_valid", res_valid, 1'b0);
        check("rst res_taken", res_taken, 1'b0);
        check("rst res_mispr", res_mispredict, 1'b0);
`ifdef BRU_STATS_EN
        check("rst stat_br",  stat_branches, 32'd0);
        check("rst stat_mis", stat_mispredicts, 32'd0);
`endif
        for (int i = 0; i < N; i++) begin
            if_pc = 32'(i * 4);
            #1 check($sformatf("rst entry%0d", i), if_pred_taken, 1'b0);
        end
        idle();
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("post-reset no result", res_valid, 1'b0);
        drive(1, 0, 3'b001, 32'h1, 32'h2, 32'h44, 1);
        tick();
        check("post-reset result", res_valid, 1'b1);
        check("post-reset taken",  res_taken, 1'b1);
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
